// File: rtl/wb_region_decoder.sv
// Wishbone decoder for the user project area: routes each registered request to one
// slave, a local debug bank, or an error response, with a per-transaction ack timeout.
module wb_region_decoder #(
   parameter int                 NSLV     = 2,
   parameter logic [NSLV*32-1:0] SLV_BASE = {32'h3000_1000, 32'h3000_0000},
   parameter logic [NSLV*32-1:0] SLV_MASK = {32'hFFFF_F000, 32'hFFFF_F000},
   parameter int                 DBG_REGS = 2,
   parameter logic [31:0]        DBG_BASE = 32'h300F_FFF8,
   parameter int                 TIMEOUT  = 255
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic                 wbs_cyc_i,
   input  logic                 wbs_stb_i,
   input  logic                 wbs_we_i,
   input  logic [3:0]           wbs_sel_i,
   input  logic [31:0]          wbs_adr_i,
   input  logic [31:0]          wbs_dat_i,
   output logic                 wbs_ack_o,
   output logic [31:0]          wbs_dat_o,
   output logic [NSLV-1:0]      s_cyc_o,
   output logic [NSLV-1:0]      s_stb_o,
   output logic                 s_we_o,
   output logic [3:0]           s_sel_o,
   output logic [31:0]          s_adr_o,
   output logic [31:0]          s_dat_o,
   input  logic [NSLV-1:0]      s_ack_i,
   input  logic [NSLV*32-1:0]   s_dat_i
);

   localparam int LG = $clog2(DBG_REGS);
   localparam int TW = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;
   typedef enum logic [1:0] {TGT_UNM = 2'd0, TGT_DBG = 2'd1, TGT_SLV = 2'd2} tgt_t;

   state_t              state_r, state_nx_s;
   tgt_t                tgt_kind_r, dec_kind_s;
   logic [2:0]          tgt_idx_r, dec_idx_s, tmo_idx_r;
   logic [NSLV-1:0]     slv_hit_s, cyc_r;
   logic                dbg_hit_s, sel_ack_s;
   logic [31:0]         sel_dat_s, dbg_rdat_s, status_s;
   logic [TW-1:0]       tmo_ctr_r;
   logic [15:0]         tmo_cnt_r;
   logic [LG-1:0]       dbg_widx_s;
   logic                capture_s, done_s, tmo_s, abort_s;
   logic [31:0]         scratch_r [0:DBG_REGS-2];

   function automatic logic [NSLV-1:0] slv_onehot(input logic [2:0] idx);
      logic [NSLV-1:0] oh;
      oh = '0;
      for (int i = 0; i < NSLV; i++) begin
         oh[i] = (idx == 3'(i));
      end
      return oh;
   endfunction

   assign s_cyc_o    = cyc_r;
   assign s_stb_o    = cyc_r;
   assign status_s   = {tmo_cnt_r, 13'd0, tmo_idx_r};
   assign dbg_widx_s = s_adr_o[2+LG-1:2];

   // Address decode: debug bank first, then lowest-index slave.
   always_comb begin
      dec_idx_s = 3'd0;
      slv_hit_s = '0;
      for (int i = NSLV - 1; i >= 0; i--) begin
         slv_hit_s[i] = ((wbs_adr_i & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]);
         dec_idx_s    = slv_hit_s[i] ? 3'(i) : dec_idx_s;
      end
      dbg_hit_s = (wbs_adr_i[31:2+LG] == DBG_BASE[31:2+LG]);
      if (dbg_hit_s) begin
         dec_kind_s = TGT_DBG;
      end else if (|slv_hit_s) begin
         dec_kind_s = TGT_SLV;
      end else begin
         dec_kind_s = TGT_UNM;
      end
   end

   // Select the latched target's ack/data and the debug read word.
   always_comb begin
      sel_ack_s  = 1'b0;
      sel_dat_s  = 32'd0;
      dbg_rdat_s = status_s;
      for (int i = 0; i < NSLV; i++) begin
         sel_ack_s = (tgt_idx_r == 3'(i)) ? s_ack_i[i] : sel_ack_s;
         sel_dat_s = (tgt_idx_r == 3'(i)) ? s_dat_i[32*i +: 32] : sel_dat_s;
      end
      for (int i = 0; i < DBG_REGS - 1; i++) begin
         dbg_rdat_s = (dbg_widx_s == LG'(i)) ? scratch_r[i] : dbg_rdat_s;
      end
   end

   // Next-state logic and transaction events.
   always_comb begin
      state_nx_s = state_r;
      capture_s  = 1'b0;
      done_s     = 1'b0;
      tmo_s      = 1'b0;
      abort_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (wbs_cyc_i && wbs_stb_i) begin
               capture_s  = 1'b1;
               state_nx_s = BUSY;
            end else begin
               state_nx_s = IDLE;
            end
         end
         BUSY: begin
            if (!wbs_cyc_i) begin
               abort_s    = 1'b1;
               state_nx_s = IDLE;
            end else if (tgt_kind_r != TGT_SLV || sel_ack_s) begin
               done_s     = 1'b1;
               state_nx_s = RESP;
            end else if (tmo_ctr_r == TW'(TIMEOUT - 1)) begin
               tmo_s      = 1'b1;
               state_nx_s = RESP;
            end else begin
               state_nx_s = BUSY;
            end
         end
         RESP:    state_nx_s = IDLE;
         default: state_nx_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Request capture, slave strobes, response data, timeout and debug registers.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wbs_ack_o  <= 1'b0;
         wbs_dat_o  <= 32'd0;
         cyc_r      <= '0;
         s_we_o     <= 1'b0;
         s_sel_o    <= 4'd0;
         s_adr_o    <= 32'd0;
         s_dat_o    <= 32'd0;
         tgt_kind_r <= TGT_UNM;
         tgt_idx_r  <= 3'd0;
         tmo_ctr_r  <= '0;
         tmo_cnt_r  <= 16'd0;
         tmo_idx_r  <= 3'd0;
         for (int i = 0; i < DBG_REGS - 1; i++) begin
            scratch_r[i] <= 32'd0;
         end
      end else begin
         wbs_ack_o <= done_s | tmo_s;
         if (capture_s) begin
            s_we_o     <= wbs_we_i;
            s_sel_o    <= wbs_sel_i;
            s_adr_o    <= wbs_adr_i;
            s_dat_o    <= wbs_dat_i;
            tgt_kind_r <= dec_kind_s;
            tgt_idx_r  <= dec_idx_s;
            cyc_r      <= (dec_kind_s == TGT_SLV) ? slv_onehot(dec_idx_s) : '0;
            tmo_ctr_r  <= '0;
         end else if (done_s || tmo_s || abort_s) begin
            cyc_r <= '0;
         end else if (state_r == BUSY) begin
            tmo_ctr_r <= tmo_ctr_r + TW'(1);
         end
         if (tmo_s) begin
            wbs_dat_o <= 32'hDEAD_BEEF;
            tmo_cnt_r <= (tmo_cnt_r == 16'hFFFF) ? tmo_cnt_r : tmo_cnt_r + 16'd1;
            tmo_idx_r <= tgt_idx_r;
         end else if (done_s) begin
            case (tgt_kind_r)
               TGT_DBG: wbs_dat_o <= dbg_rdat_s;
               TGT_SLV: wbs_dat_o <= sel_dat_s;
               default: wbs_dat_o <= 32'hBAD0_ADD0;
            endcase
            if (tgt_kind_r == TGT_DBG && s_we_o) begin
               if (dbg_widx_s == LG'(DBG_REGS - 1)) begin
                  tmo_cnt_r <= 16'd0;
                  tmo_idx_r <= 3'd0;
               end
               for (int i = 0; i < DBG_REGS - 1; i++) begin
                  for (int b = 0; b < 4; b++) begin
                     if (dbg_widx_s == LG'(i) && s_sel_o[b]) begin
                        scratch_r[i][8*b +: 8] <= s_dat_o[8*b +: 8];
                     end
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_wb_region_decoder.sv
// Self-checking bench for wb_region_decoder: vector table with a scoreboard queue,
// plus hand-written abort and reset-during-BUSY sequences.
module tb_wb_region_decoder;

   localparam int NSLV = 2;
   localparam int TMO  = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              cyc, stb, we;
   logic [3:0]        sel;
   logic [31:0]       adr, wdat;
   logic              ack;
   logic [31:0]       rdat;
   logic [NSLV-1:0]   s_cyc, s_stb, s_ack;
   logic              s_we;
   logic [3:0]        s_sel;
   logic [31:0]       s_adr, s_dat;
   logic [NSLV*32-1:0] s_rdat;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      bit          is_slv;
      int          slot;
      int          ack_cyc;   // BUSY cycle in which the slave acks, 0 = never
      logic [31:0] ack_dat;
      bit          chk_dat;
      logic [31:0] exp_dat;
      int          exp_lat;
   } vec_t;

   typedef struct {
      logic [31:0] dat;
      int          lat;
      bit          chk;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs[15];

   wb_region_decoder #(.NSLV(NSLV), .TIMEOUT(TMO)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
      .wbs_adr_i(adr), .wbs_dat_i(wdat),
      .wbs_ack_o(ack), .wbs_dat_o(rdat),
      .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
      .s_adr_o(s_adr), .s_dat_o(s_dat),
      .s_ack_i(s_ack), .s_dat_i(s_rdat)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, input bit sl, input int slot,
                               input int ac, input logic [31:0] ad, input bit c,
                               input logic [31:0] ed, input int el);
      vec_t v;
      v.we = w; v.adr = a; v.dat = d; v.sel = s; v.is_slv = sl; v.slot = slot;
      v.ack_cyc = ac; v.ack_dat = ad; v.chk_dat = c; v.exp_dat = ed; v.exp_lat = el;
      return v;
   endfunction

   task automatic run_vec(input vec_t v, input int n);
      exp_t e, got_e;
      bit   got;
      logic [NSLV-1:0] oh;
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = v.we; adr = v.adr; wdat = v.dat; sel = v.sel;
      for (int j = 0; j < NSLV; j++) begin
         s_rdat[32*j +: 32] = (j == v.slot) ? v.ack_dat : (32'h5555_0000 | 32'(j));
      end
      e.dat = v.exp_dat; e.lat = v.exp_lat; e.chk = v.chk_dat;
      sb_q.push_back(e);
      @(posedge clk); #1;
      got = 1'b0;
      for (int c = 1; c <= 30 && !got; c++) begin
         if (c == 1 && v.is_slv) begin
            oh = '0;
            oh[v.slot] = 1'b1;
            chk($sformatf("v%0d s_cyc", n), 32'(s_cyc), 32'(oh));
            chk($sformatf("v%0d s_stb", n), 32'(s_stb), 32'(oh));
            chk($sformatf("v%0d s_adr", n), s_adr, v.adr);
            chk($sformatf("v%0d s_we", n), 32'(s_we), 32'(v.we));
         end
         if (ack) begin
            got = 1'b1;
            if (sb_q.size() == 0) begin
               chk($sformatf("v%0d unexpected_ack", n), 32'd1, 32'd0);
            end else begin
               got_e = sb_q.pop_front();
               chk($sformatf("v%0d ack_cycle", n), 32'(c), 32'(got_e.lat));
               if (got_e.chk) chk($sformatf("v%0d data", n), rdat, got_e.dat);
            end
         end else begin
            s_ack = '0;
            if (v.is_slv && c == v.ack_cyc) s_ack[v.slot] = 1'b1;
            else if (v.is_slv && c == 1) s_ack[1 - v.slot] = 1'b1;
            @(posedge clk); #1;
         end
      end
      s_ack = '0; cyc = 1'b0; stb = 1'b0;
      if (!got) begin
         chk($sformatf("v%0d ack_timeout", n), 32'd0, 32'd1);
         void'(sb_q.pop_front());
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d single_ack", n), 32'(ack), 32'd0);
   endtask

   initial begin
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'd0;
      adr = 32'd0; wdat = 32'd0; s_ack = '0; s_rdat = '0;

      vecs[0]  = mk(1'b1, 32'h300F_FFF8, 32'h1234_5678, 4'b0011, 1'b0, 0, 0, 32'd0, 1'b0, 32'd0, 2);
      vecs[1]  = mk(1'b0, 32'h300F_FFF8, 32'd0, 4'b1111, 1'b0, 0, 0, 32'd0, 1'b1, 32'h0000_5678, 2);
      vecs[2]  = mk(1'b1, 32'h300F_FFF8, 32'hFFFF_FFFF, 4'b1100, 1'b0, 0, 0, 32'd0, 1'b0, 32'd0, 2);
      vecs[3]  = mk(1'b0, 32'h300F_FFF8, 32'd0, 4'b1111, 1'b0, 0, 0, 32'd0, 1'b1, 32'hFFFF_5678, 2);
      vecs[4]  = mk(1'b0, 32'h3000_1004, 32'd0, 4'b1111, 1'b1, 1, 4, 32'hCAFE_0001, 1'b1, 32'hCAFE_0001, 5);
      vecs[5]  = mk(1'b0, 32'h3000_0010, 32'd0, 4'b1111, 1'b1, 0, 0, 32'd0, 1'b1, 32'hDEAD_BEEF, TMO + 1);
      vecs[6]  = mk(1'b0, 32'h300F_FFFC, 32'd0, 4'b1111, 1'b0, 0, 0, 32'd0, 1'b1, 32'h0001_0000, 2);
      vecs[7]  = mk(1'b1, 32'h300F_FFFC, 32'h0000_0000, 4'b0001, 1'b0, 0, 0, 32'd0, 1'b0, 32'd0, 2);
      vecs[8]  = mk(1'b0, 32'h300F_FFFC, 32'd0, 4'b1111, 1'b0, 0, 0, 32'd0, 1'b1, 32'h0000_0000, 2);
      vecs[9]  = mk(1'b1, 32'h3000_0020, 32'h0BAD_F00D, 4'b1111, 1'b1, 0, TMO, 32'hA5A5_0000, 1'b1, 32'hA5A5_0000, TMO + 1);
      vecs[10] = mk(1'b0, 32'h300F_FFFC, 32'd0, 4'b1111, 1'b0, 0, 0, 32'd0, 1'b1, 32'h0000_0000, 2);
      vecs[11] = mk(1'b0, 32'h2000_0000, 32'd0, 4'b1111, 1'b0, 0, 0, 32'd0, 1'b1, 32'hBAD0_ADD0, 2);
      vecs[12] = mk(1'b0, 32'h3000_1FFC, 32'd0, 4'b1111, 1'b1, 1, 0, 32'd0, 1'b1, 32'hDEAD_BEEF, TMO + 1);
      vecs[13] = mk(1'b0, 32'h300F_FFFC, 32'd0, 4'b1111, 1'b0, 0, 0, 32'd0, 1'b1, 32'h0001_0001, 2);
      vecs[14] = mk(1'b0, 32'h3000_0000, 32'd0, 4'b1111, 1'b1, 0, 1, 32'h1111_2222, 1'b1, 32'h1111_2222, 2);

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst ack", 32'(ack), 32'd0);
      chk("rst dat", rdat, 32'd0);
      chk("rst s_cyc", 32'(s_cyc), 32'd0);
      chk("rst s_stb", 32'(s_stb), 32'd0);
      chk("rst s_req", {27'd0, s_we, s_sel}, 32'd0);
      chk("rst s_adr", s_adr, 32'd0);
      chk("rst s_dat", s_dat, 32'd0);

      for (int i = 0; i < 15; i++) begin
         run_vec(vecs[i], i);
      end

      // Abort: master drops cyc in BUSY cycle 3 while slave 0 stays silent.
      begin
         int acks;
         @(posedge clk); #1;
         cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0040; sel = 4'hF;
         @(posedge clk); #1;
         @(posedge clk); #1;
         @(posedge clk); #1;
         cyc = 1'b0; stb = 1'b0;
         @(posedge clk); #1;
         chk("abort s_cyc", 32'(s_cyc), 32'd0);
         acks = 0;
         for (int c = 0; c < 3 * TMO; c++) begin
            acks += int'(ack);
            @(posedge clk); #1;
         end
         chk("abort no_ack", 32'(acks), 32'd0);
      end
      run_vec(mk(1'b0, 32'h300F_FFFC, 32'd0, 4'hF, 1'b0, 0, 0, 32'd0, 1'b1, 32'h0001_0001, 2), 20);

      // Reset while BUSY on slave 1.
      begin
         int acks;
         @(posedge clk); #1;
         cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_1008; wdat = 32'h7777_8888; sel = 4'hF;
         @(posedge clk); #1;
         chk("busy s_cyc", 32'(s_cyc), 32'd2);
         @(posedge clk); #1;
         rst = 1'b1; cyc = 1'b0; stb = 1'b0;
         @(posedge clk); #1;
         rst = 1'b0;
         chk("rbusy ack", 32'(ack), 32'd0);
         chk("rbusy dat", rdat, 32'd0);
         chk("rbusy s_cyc", 32'(s_cyc | s_stb), 32'd0);
         chk("rbusy s_req", {27'd0, s_we, s_sel}, 32'd0);
         chk("rbusy s_adr", s_adr, 32'd0);
         chk("rbusy s_dat", s_dat, 32'd0);
         acks = 0;
         for (int c = 0; c < 2 * TMO; c++) begin
            acks += int'(ack);
            @(posedge clk); #1;
         end
         chk("rbusy no_ack", 32'(acks), 32'd0);
      end
      run_vec(mk(1'b0, 32'h300F_FFFC, 32'd0, 4'hF, 1'b0, 0, 0, 32'd0, 1'b1, 32'h0000_0000, 2), 21);
      run_vec(mk(1'b0, 32'h300F_FFF8, 32'd0, 4'hF, 1'b0, 0, 0, 32'd0, 1'b1, 32'h0000_0000, 2), 22);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
